seven_seg_scan: RTL
===================

Name: seven_seg_scan

Overview:
Time-multiplexed scan controller for the 4-digit common-anode display. It holds a 4-digit BCD value with per-digit decimal points and rotates the active-low anodes, one digit per refresh slot. Each slot drives the existing seven_seg decoder with that digit's BCD code. New values are double-buffered and committed only at frame boundaries to prevent tearing. A blanking interval at the start of each slot suppresses ghosting.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (min 4).
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe; captures value_in/dp_in/lz_en into the pending buffer
value_in  input  16  four BCD digits; [3:0] = digit0 (rightmost)
dp_in  input  4  decimal point per digit, 1 = lit; bit i maps to digit i
lz_en  input  1  leading-zero suppression enable
an  output  4  anode enables, active low; an[i] drives digit i
seg  output  8  cathodes, active low; [7] = dp, [6:0] = g..a
frame_done  output  1  one-cycle pulse on the last cycle of digit 3's slot
pending  output  1  1 while a loaded value is waiting for commit

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0: an=4'b1111, seg=8'hFF, frame_done=0, pending=0, slot counter=0, digit index=0, state=BLANK, display and pending buffers all zero.
- Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0. On wrap, digit index advances 0->1->2->3->0.
- FSM, per slot:
  - BLANK while counter < BLANK_CYCLES.
  - SHOW for the remaining cycles.
  - Transitions: BLANK->SHOW at counter==BLANK_CYCLES; SHOW->BLANK at wrap.
- Outputs are registered and have no combinational path from inputs.
  - BLANK: an=1111, seg=FF.
  - SHOW: an has only bit [idx] low; seg = decoder(digit[idx]) with bit7 cleared if dp[idx]=1.
- Cycle timing: in the first cycle after rst_n rises, the counter reads 0. The outputs for counter value k appear in cycle k+1.
- Decoder mapping (from seven_seg): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Codes A-F give FF; dp is still applied.
- Leading-zero suppression: when committed lz_en=1, digit i (i>=1) is suppressed if it and all higher digits equal 0.
  - A suppressed digit has its anode still enabled and seg[6:0]=7F; its dp is still honoured.
  - Digit 0 is never suppressed.
- Load handshake:
  - load=1 copies value_in, dp_in and lz_en into the pending buffer and sets pending=1 on the next edge.
  - A repeated load before commit overwrites the buffer; last load wins.
- Commit occurs at the frame boundary, i.e. the cycle with digit index 3 and counter wrapping.
  - If pending=1, the pending buffer is copied to the display buffer and pending clears.
  - If load=1 in that same cycle, value_in is committed directly and pending stays 0.
- frame_done asserts on the same cycle as the commit edge, whether or not a commit happens.
- Reset mid-scan: outputs blank immediately (asynchronously); any pending value is discarded.

Decomposition:
- Shared package: SEG_BLANK=8'hFF, SEG_DP_BIT=7, ANODE_OFF=4'hF, NUM_DIGITS=4, FSM state enum {BLANK, SHOW}.
- Instantiate the existing seven_seg decoder as the single sub-module.
- Slot counter, digit index, FSM, buffers and output registers live in seven_seg_scan.

Test Plan (all with REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset: hold rst_n=0 with load=1 -> an=1111, seg=FF, pending=0, frame_done=0. Assert rst_n=0 mid-SHOW -> an=1111 before the next edge.
- Scan: load 16'h1234, dp_in=4'b0001, then wait for commit. Each slot shows 2 cycles of an=1111/seg=FF, then 6 cycles of:
  - an=1110, seg=19 (digit 4 with dp)
  - an=1101, seg=B0
  - an=1011, seg=A4
  - an=0111, seg=F9
  - frame_done pulses once every 32 cycles.
- Leading zero: load 16'h0050 with lz_en=1 -> digit3 and digit2 show seg=FF, digit1 shows 92, digit0 shows C0. Same value with lz_en=0 -> digit3 and digit2 show C0.
- Invalid BCD: load 16'h00A0 -> digit1 slot shows seg=FF with an=1101.
- Deferred commit: load 16'h1111 during digit1 of a frame -> pending=1 and display unchanged through digit3. The next frame shows F9 on all digits and pending drops on the frame_done edge.
- Collisions:
  - load coincident with the frame boundary -> the new value is displayed in the next frame and pending stays 0.
  - Two loads (16'h2222, then 16'h3333) before the boundary -> only 3333 is shown.

Source files
------------

// File: rtl/seven_seg_scan_pkg.sv
// Shared constants, FSM state type and display buffer layout for the
// four-digit scanned seven-segment display controller.
package seven_seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_DP_BIT = 7;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [3:0]  ANODE_OFF  = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // One complete display image: BCD digits, decimal points, zero suppression
  typedef struct packed {
    logic        lz;
    logic [3:0]  dp;
    logic [15:0] value;
  } disp_t;

endpackage

// File: rtl/seven_seg.sv
// BCD to seven-segment decoder, active-low cathodes.
// Ports: bcd - 4-bit digit code; seg_c - segments g..a, active low
//        (codes A-F light nothing).
module seven_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (bcd)
      4'd0: seg_c = 7'h40;
      4'd1: seg_c = 7'h79;
      4'd2: seg_c = 7'h24;
      4'd3: seg_c = 7'h30;
      4'd4: seg_c = 7'h19;
      4'd5: seg_c = 7'h12;
      4'd6: seg_c = 7'h02;
      4'd7: seg_c = 7'h78;
      4'd8: seg_c = 7'h00;
      4'd9: seg_c = 7'h10;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Each digit owns a REFRESH_DIV-cycle slot; the first BLANK_CYCLES of a
// slot keep all anodes off. Loaded values wait in a pending buffer and
// are committed at the frame boundary so a frame never mixes two values.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load        - strobe capturing value_in/dp_in/lz_en
//   value_in    - four BCD digits, [3:0] = rightmost digit
//   dp_in       - decimal point per digit, 1 = lit
//   lz_en       - leading-zero suppression enable
//   an          - anodes, active low
//   seg         - cathodes, active low, [7] = dp
//   frame_done  - pulse on the last cycle of digit 3's slot
//   pending     - a loaded value awaits commit
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  scan_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    idx, idx_d;
  disp_t         disp, disp_d;
  disp_t         pend_buf, pend_buf_d;
  logic          pending_d;
  logic [3:0]    an_d;
  logic [7:0]    seg_d;
  logic          frame_done_d;

  logic          cnt_wrap;
  logic          frame_end;
  logic [3:0]    cur_bcd;
  logic [6:0]    dec_seg;
  logic          suppress;
  disp_t         incoming;

  // Digit currently being scanned goes through the shared decoder
  assign cur_bcd = disp.value[{idx, 2'b00} +: 4];

  seven_seg u_dec (
    .bcd   (cur_bcd),
    .seg_c (dec_seg)
  );

  // All registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      pend_buf   <= '0;
      pending    <= 1'b0;
      an         <= ANODE_OFF;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      disp       <= disp_d;
      pend_buf   <= pend_buf_d;
      pending    <= pending_d;
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= frame_done_d;
    end
  end

  // Next-state, buffer handshake and output decode
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    disp_d       = disp;
    pend_buf_d   = pend_buf;
    pending_d    = pending;
    an_d         = ANODE_OFF;
    seg_d        = SEG_BLANK;
    frame_done_d = 1'b0;
    suppress     = 1'b0;
    incoming     = '{lz: lz_en, dp: dp_in, value: value_in};

    cnt_wrap  = (cnt == CW'(REFRESH_DIV - 1));
    frame_end = cnt_wrap && (idx == 2'd3);

    // Slot counter and digit rotation
    if (cnt_wrap) begin
      cnt_d = '0;
      idx_d = idx + 2'd1;
    end else begin
      cnt_d = cnt + CW'(1);
    end

    case (state)
      BLANK: if (cnt == CW'(BLANK_CYCLES - 1)) state_d = SHOW;
      SHOW:  if (cnt_wrap) state_d = BLANK;
      default: state_d = BLANK;
    endcase

    // Last load wins; a load on the boundary bypasses the pending buffer
    if (load) begin
      pend_buf_d = incoming;
      pending_d  = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        disp_d    = incoming;
        pending_d = 1'b0;
      end else if (pending) begin
        disp_d    = pend_buf;
        pending_d = 1'b0;
      end
    end

    // Digit i>=1 is blank when it and every higher digit are zero
    case (idx)
      2'd1: suppress = disp.lz && (disp.value[15:4]  == 12'h000);
      2'd2: suppress = disp.lz && (disp.value[15:8]  == 8'h00);
      2'd3: suppress = disp.lz && (disp.value[15:12] == 4'h0);
      default: suppress = 1'b0;
    endcase

    if (state == SHOW) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = suppress ? SEG_BLANK : {1'b1, dec_seg};
      if (disp.dp[idx]) seg_d[SEG_DP_BIT] = 1'b0;
    end

    frame_done_d = frame_end;
  end

endmodule
